uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter (8 data bits, LSB first, one stop bit) fed by a small circular FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
  parameter int CLKBIT     = 12000000/115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx_done,
  output logic       overflow,
  output logic       tx
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = ($clog2(CLKBIT) > 11) ? $clog2(CLKBIT) : 11;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state, state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic [CW-1:0] bcnt, bcnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    data_q;
  logic          tx_nxt, done_nxt, pop, wr_ok, bit_end;

  assign full    = (cnt == (AW+1)'(FIFO_DEPTH));
  assign empty   = (cnt == '0);
  assign busy    = (state != IDLE);
  assign wr_ok   = wr_en && !full;
  assign bit_end = (bcnt == CW'(CLKBIT-1));

  // FIFO storage carries no reset; validity is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (pop)   rptr <= rptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bcnt    <= '0;
      idx     <= '0;
      data_q  <= '0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      bcnt    <= bcnt_nxt;
      idx     <= idx_nxt;
      tx      <= tx_nxt;
      tx_done <= done_nxt;
      if (pop) data_q <= mem[rptr];
    end
  end

  // tx is registered from the next-state decision so a bit appears on the edge that enters it.
  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bit_end ? '0 : bcnt + CW'(1);
    idx_nxt   = idx;
    tx_nxt    = tx;
    done_nxt  = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        bcnt_nxt = '0;
        tx_nxt   = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          idx_nxt   = '0;
          tx_nxt    = data_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
            tx_nxt    = ^data_q;
`else
            state_nxt = STOP;
            tx_nxt    = 1'b1;
`endif
          end else begin
            idx_nxt = idx + 3'd1;
            tx_nxt  = data_q[idx + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          done_nxt = 1'b1;
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule
